// File: rtl/pipelined_control_unit.sv
// Registered MIPS control decoder feeding the ID/EX slot, with load-use hazard
// detection and a SYSCALL drain FSM. Optional SLL/SRL decode: SHIFT_DECODE_EN.
module pipelined_control_unit #(
  parameter int ALUOP_W      = 4,
  parameter int REG_ADDR_W   = 5,
  parameter int DRAIN_CYCLES = 3,
  parameter int LINK_REG     = 31
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  input  logic [5:0]            id_opcode,
  input  logic [5:0]            id_func,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  stall_in,
  input  logic                  flush,
  output logic                  id_stall,
  output logic                  ex_valid,
  output logic                  ex_reg_write,
  output logic                  ex_mem_read,
  output logic                  ex_mem_write,
  output logic                  ex_mem_to_reg,
  output logic                  ex_alu_src,
  output logic                  ex_branch,
  output logic                  ex_bne,
  output logic                  ex_jump,
  output logic                  ex_jr,
  output logic                  ex_jal,
  output logic [ALUOP_W-1:0]    ex_alu_op,
  output logic [REG_ADDR_W-1:0] ex_wreg,
  output logic                  ex_illegal,
  output logic                  sys_busy,
  output logic                  sys_fire
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_DRAIN = 2'd1;
  localparam logic [1:0] S_FIRE  = 2'd2;

  localparam logic [1:0] WS_NONE = 2'd0;
  localparam logic [1:0] WS_RD   = 2'd1;
  localparam logic [1:0] WS_RT   = 2'd2;
  localparam logic [1:0] WS_LINK = 2'd3;

  localparam int C_RW = 9, C_MR = 8, C_MW = 7, C_M2R = 6, C_AS = 5;
  localparam int C_BR = 4, C_BNE = 3, C_J = 2, C_JR = 1, C_JAL = 0;

  localparam logic [ALUOP_W-1:0] OP_AND = ALUOP_W'(3'b000);
  localparam logic [ALUOP_W-1:0] OP_OR  = ALUOP_W'(3'b001);
  localparam logic [ALUOP_W-1:0] OP_ADD = ALUOP_W'(3'b010);
  localparam logic [ALUOP_W-1:0] OP_LUI = ALUOP_W'(3'b011);
  localparam logic [ALUOP_W-1:0] OP_SUB = ALUOP_W'(3'b110);
  localparam logic [ALUOP_W-1:0] OP_SLT = ALUOP_W'(3'b111);
`ifdef SHIFT_DECODE_EN
  localparam logic [ALUOP_W-1:0] OP_SLL = ALUOP_W'(4'b1000);
  localparam logic [ALUOP_W-1:0] OP_SRL = ALUOP_W'(4'b1001);
`endif

  localparam logic [3:0]            DRAIN_INIT = 4'(DRAIN_CYCLES - 1);
  localparam logic [REG_ADDR_W-1:0] LINK       = REG_ADDR_W'(LINK_REG);

  logic [9:0]            dec_ctrl;
  logic [ALUOP_W-1:0]    dec_alu;
  logic [1:0]            dec_wsel;
  logic [REG_ADDR_W-1:0] dec_wreg;
  logic                  dec_ill, dec_sys, dec_uses_rt, zero_word, hazard;

  logic                  ex_valid_q, ex_valid_d, ex_ill_q, ex_ill_d;
  logic [9:0]            ex_ctrl_q, ex_ctrl_d;
  logic [ALUOP_W-1:0]    ex_alu_q, ex_alu_d;
  logic [REG_ADDR_W-1:0] ex_wreg_q, ex_wreg_d;
  logic [1:0]            state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;

  assign zero_word = (id_opcode == 6'h00) && (id_func == 6'h00) &&
                     (id_rs == '0) && (id_rt == '0) && (id_rd == '0);

  always_comb begin
    dec_ctrl    = '0;
    dec_alu     = '0;
    dec_wsel    = WS_NONE;
    dec_ill     = 1'b0;
    dec_sys     = 1'b0;
    dec_uses_rt = 1'b0;
    case (id_opcode)
      6'h00: begin
        dec_uses_rt = 1'b1;
        case (id_func)
          6'h20, 6'h21: begin dec_ctrl[C_RW] = 1'b1; dec_alu = OP_ADD; dec_wsel = WS_RD; end
          6'h22:        begin dec_ctrl[C_RW] = 1'b1; dec_alu = OP_SUB; dec_wsel = WS_RD; end
          6'h24:        begin dec_ctrl[C_RW] = 1'b1; dec_alu = OP_AND; dec_wsel = WS_RD; end
          6'h25:        begin dec_ctrl[C_RW] = 1'b1; dec_alu = OP_OR;  dec_wsel = WS_RD; end
          6'h2A:        begin dec_ctrl[C_RW] = 1'b1; dec_alu = OP_SLT; dec_wsel = WS_RD; end
          6'h08:        dec_ctrl[C_JR] = 1'b1;
          6'h0C:        dec_sys = 1'b1;
`ifdef SHIFT_DECODE_EN
          6'h00:        begin dec_ctrl[C_RW] = !zero_word; dec_alu = OP_SLL; dec_wsel = WS_RD; end
          6'h02:        begin dec_ctrl[C_RW] = 1'b1; dec_alu = OP_SRL; dec_wsel = WS_RD; end
`else
          6'h00:        dec_ill = !zero_word;
`endif
          default:      dec_ill = 1'b1;
        endcase
      end
      6'h08, 6'h09: begin dec_ctrl[C_RW] = 1'b1; dec_ctrl[C_AS] = 1'b1; dec_alu = OP_ADD; dec_wsel = WS_RT; end
      6'h0D:        begin dec_ctrl[C_RW] = 1'b1; dec_ctrl[C_AS] = 1'b1; dec_alu = OP_OR;  dec_wsel = WS_RT; end
      6'h0F:        begin dec_ctrl[C_RW] = 1'b1; dec_ctrl[C_AS] = 1'b1; dec_alu = OP_LUI; dec_wsel = WS_RT; end
      6'h23: begin
        dec_ctrl[C_RW] = 1'b1; dec_ctrl[C_MR] = 1'b1; dec_ctrl[C_M2R] = 1'b1;
        dec_ctrl[C_AS] = 1'b1; dec_alu = OP_ADD; dec_wsel = WS_RT;
      end
      6'h2B: begin dec_ctrl[C_MW] = 1'b1; dec_ctrl[C_AS] = 1'b1; dec_alu = OP_ADD; dec_uses_rt = 1'b1; end
      6'h04: begin dec_ctrl[C_BR] = 1'b1; dec_alu = OP_SUB; dec_uses_rt = 1'b1; end
      6'h05: begin dec_ctrl[C_BR] = 1'b1; dec_ctrl[C_BNE] = 1'b1; dec_alu = OP_SUB; dec_uses_rt = 1'b1; end
      6'h02: dec_ctrl[C_J] = 1'b1;
      6'h03: begin dec_ctrl[C_J] = 1'b1; dec_ctrl[C_JAL] = 1'b1; dec_ctrl[C_RW] = 1'b1; dec_wsel = WS_LINK; end
      default: dec_ill = 1'b1;
    endcase
  end

  always_comb begin
    case (dec_wsel)
      WS_RD:   dec_wreg = id_rd;
      WS_RT:   dec_wreg = id_rt;
      WS_LINK: dec_wreg = LINK;
      default: dec_wreg = '0;
    endcase
  end

  assign hazard = id_valid && ex_valid_q && ex_ctrl_q[C_MR] && (ex_wreg_q != '0) &&
                  ((ex_wreg_q == id_rs) || (dec_uses_rt && (ex_wreg_q == id_rt)));
  assign id_stall = hazard || (state_q != S_IDLE);

  // Defaults describe a bubble; only the IDLE path with a clean ID slot issues.
  always_comb begin
    ex_valid_d = 1'b0;
    ex_ctrl_d  = '0;
    ex_alu_d   = '0;
    ex_wreg_d  = '0;
    ex_ill_d   = 1'b0;
    state_d    = state_q;
    cnt_d      = cnt_q;
    if (stall_in) begin
      ex_valid_d = ex_valid_q;
      ex_ctrl_d  = ex_ctrl_q;
      ex_alu_d   = ex_alu_q;
      ex_wreg_d  = ex_wreg_q;
      ex_ill_d   = ex_ill_q;
    end else if (flush) begin
      if (state_q != S_IDLE) begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    end else begin
      case (state_q)
        S_IDLE: begin
          if (id_valid && !hazard) begin
            if (dec_sys) begin
              state_d = S_DRAIN;
              cnt_d   = DRAIN_INIT;
            end else begin
              ex_valid_d = 1'b1;
              ex_ctrl_d  = dec_ctrl;
              ex_alu_d   = dec_alu;
              ex_wreg_d  = dec_wreg;
              ex_ill_d   = dec_ill;
            end
          end
        end
        S_DRAIN: begin
          if (cnt_q == '0) state_d = S_FIRE;
          else             cnt_d   = cnt_q - 4'd1;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid_q <= 1'b0;
      ex_ctrl_q  <= '0;
      ex_alu_q   <= '0;
      ex_wreg_q  <= '0;
      ex_ill_q   <= 1'b0;
      state_q    <= S_IDLE;
      cnt_q      <= '0;
    end else begin
      ex_valid_q <= ex_valid_d;
      ex_ctrl_q  <= ex_ctrl_d;
      ex_alu_q   <= ex_alu_d;
      ex_wreg_q  <= ex_wreg_d;
      ex_ill_q   <= ex_ill_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
    end
  end

  assign ex_valid      = ex_valid_q;
  assign ex_reg_write  = ex_ctrl_q[C_RW];
  assign ex_mem_read   = ex_ctrl_q[C_MR];
  assign ex_mem_write  = ex_ctrl_q[C_MW];
  assign ex_mem_to_reg = ex_ctrl_q[C_M2R];
  assign ex_alu_src    = ex_ctrl_q[C_AS];
  assign ex_branch     = ex_ctrl_q[C_BR];
  assign ex_bne        = ex_ctrl_q[C_BNE];
  assign ex_jump       = ex_ctrl_q[C_J];
  assign ex_jr         = ex_ctrl_q[C_JR];
  assign ex_jal        = ex_ctrl_q[C_JAL];
  assign ex_alu_op     = ex_alu_q;
  assign ex_wreg       = ex_wreg_q;
  assign ex_illegal    = ex_ill_q;
  assign sys_busy      = (state_q != S_IDLE);
  assign sys_fire      = (state_q == S_FIRE);

endmodule

// File: tb/tb_pipelined_control_unit.sv
// Directed bench for pipelined_control_unit: decode, load-use stall, flush,
// external stall and the SYSCALL drain sequence (DRAIN_CYCLES=3).
module tb_pipelined_control_unit;

  logic       clk, rst, id_valid, stall_in, flush;
  logic [5:0] id_opcode, id_func;
  logic [4:0] id_rs, id_rt, id_rd;
  logic       id_stall, ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg;
  logic       ex_alu_src, ex_branch, ex_bne, ex_jump, ex_jr, ex_jal, ex_illegal;
  logic       sys_busy, sys_fire;
  logic [3:0] ex_alu_op;
  logic [4:0] ex_wreg;

  int checks = 0;
  int errors = 0;

  localparam logic [11:0] V  = 12'h800, RW = 12'h400, MR  = 12'h200, MW  = 12'h100;
  localparam logic [11:0] M2R = 12'h080, AS = 12'h040, BR = 12'h020, BNE = 12'h010;
  localparam logic [11:0] J  = 12'h008, JR = 12'h004, JAL = 12'h002, ILL = 12'h001;

  pipelined_control_unit #(
    .ALUOP_W(4), .REG_ADDR_W(5), .DRAIN_CYCLES(3), .LINK_REG(31)
  ) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_opcode(id_opcode), .id_func(id_func),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .stall_in(stall_in), .flush(flush),
    .id_stall(id_stall), .ex_valid(ex_valid), .ex_reg_write(ex_reg_write),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_mem_to_reg(ex_mem_to_reg),
    .ex_alu_src(ex_alu_src), .ex_branch(ex_branch), .ex_bne(ex_bne), .ex_jump(ex_jump),
    .ex_jr(ex_jr), .ex_jal(ex_jal), .ex_alu_op(ex_alu_op), .ex_wreg(ex_wreg),
    .ex_illegal(ex_illegal), .sys_busy(sys_busy), .sys_fire(sys_fire)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [11:0] ex_bits();
    return {ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_alu_src,
            ex_branch, ex_bne, ex_jump, ex_jr, ex_jal, ex_illegal};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_ex(input string tag, input logic [11:0] bits, input logic [3:0] alu,
                        input logic [4:0] wreg);
    chk({tag, ".ctl"}, 32'(ex_bits()), 32'(bits));
    chk({tag, ".alu"}, 32'(ex_alu_op), 32'(alu));
    chk({tag, ".wreg"}, 32'(ex_wreg), 32'(wreg));
  endtask

  task automatic chk_sys(input string tag, input logic busy, input logic fire, input logic stl);
    chk({tag, ".busy"}, 32'(sys_busy), 32'(busy));
    chk({tag, ".fire"}, 32'(sys_fire), 32'(fire));
    chk({tag, ".stall"}, 32'(id_stall), 32'(stl));
  endtask

  task automatic ins(input logic v, input logic [5:0] op, input logic [5:0] fn,
                     input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
    id_valid = v; id_opcode = op; id_func = fn; id_rs = rs; id_rt = rt; id_rd = rd;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; stall_in = 1'b0; flush = 1'b0;
    ins(1'b0, 6'h00, 6'h00, 5'd0, 5'd0, 5'd0);
    #1 rst = 1'b1;
    #2;
    chk_ex("reset", 12'h000, 4'h0, 5'd0);
    chk_sys("reset", 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // ADD $3,$1,$2
    ins(1'b1, 6'h00, 6'h20, 5'd1, 5'd2, 5'd3);
    tick(); chk_ex("add", V | RW, 4'h2, 5'd3);

    // LW $5 then ADD $6,$5,$1: one stall, one bubble, then ADD
    ins(1'b1, 6'h23, 6'h00, 5'd2, 5'd5, 5'd0);
    tick(); chk_ex("lw", V | RW | MR | M2R | AS, 4'h2, 5'd5);
    ins(1'b1, 6'h00, 6'h20, 5'd5, 5'd1, 5'd6);
    #1 chk("lu_rs.stall", 32'(id_stall), 32'd1);
    tick(); chk_ex("lu_bubble", 12'h000, 4'h0, 5'd0);
    chk("lu_after.stall", 32'(id_stall), 32'd0);
    tick(); chk_ex("lu_add", V | RW, 4'h2, 5'd6);

    // LW $5 then SUB $7,$1,$5: rt dependency stalls
    ins(1'b1, 6'h23, 6'h00, 5'd2, 5'd5, 5'd0);
    tick();
    ins(1'b1, 6'h00, 6'h22, 5'd1, 5'd5, 5'd7);
    #1 chk("lu_rt.stall", 32'(id_stall), 32'd1);
    // ADDI with rt=$5 does not read rt
    ins(1'b1, 6'h08, 6'h00, 5'd1, 5'd5, 5'd0);
    #1 chk("lu_addi.stall", 32'(id_stall), 32'd0);
    tick(); chk_ex("addi", V | RW | AS, 4'h2, 5'd5);

    // LW $0 then ADD $6,$0,$1: no stall on $0
    ins(1'b1, 6'h23, 6'h00, 5'd2, 5'd0, 5'd0);
    tick();
    ins(1'b1, 6'h00, 6'h20, 5'd0, 5'd1, 5'd6);
    #1 chk("lu_zero.stall", 32'(id_stall), 32'd0);
    tick(); chk_ex("lu_zero_add", V | RW, 4'h2, 5'd6);

    // Assorted decode
    ins(1'b1, 6'h03, 6'h00, 5'd0, 5'd0, 5'd0);
    tick(); chk_ex("jal", V | RW | J | JAL, 4'h0, 5'd31);
    ins(1'b1, 6'h05, 6'h00, 5'd1, 5'd2, 5'd9);
    tick(); chk_ex("bne", V | BR | BNE, 4'h6, 5'd0);
    ins(1'b1, 6'h0F, 6'h00, 5'd0, 5'd8, 5'd0);
    tick(); chk_ex("lui", V | RW | AS, 4'h3, 5'd8);
    ins(1'b1, 6'h2B, 6'h00, 5'd1, 5'd2, 5'd0);
    tick(); chk_ex("sw", V | MW | AS, 4'h2, 5'd0);
    ins(1'b1, 6'h00, 6'h08, 5'd31, 5'd0, 5'd0);
    tick(); chk_ex("jr", V | JR, 4'h0, 5'd0);
    ins(1'b1, 6'h00, 6'h2A, 5'd1, 5'd2, 5'd4);
    tick(); chk_ex("slt", V | RW, 4'h7, 5'd4);
    ins(1'b1, 6'h3F, 6'h00, 5'd1, 5'd2, 5'd3);
    tick(); chk_ex("illegal_op", V | ILL, 4'h0, 5'd0);
    ins(1'b1, 6'h00, 6'h02, 5'd0, 5'd1, 5'd4);
`ifdef SHIFT_DECODE_EN
    tick(); chk_ex("srl", V | RW, 4'h9, 5'd4);
    ins(1'b1, 6'h00, 6'h00, 5'd0, 5'd0, 5'd0);
    tick(); chk_ex("nop", V, 4'h8, 5'd0);
`else
    tick(); chk_ex("srl_ill", V | ILL, 4'h0, 5'd0);
    ins(1'b1, 6'h00, 6'h00, 5'd0, 5'd0, 5'd0);
    tick(); chk_ex("nop", V, 4'h0, 5'd0);
`endif
    ins(1'b0, 6'h00, 6'h20, 5'd1, 5'd2, 5'd3);
    tick(); chk_ex("invalid", 12'h000, 4'h0, 5'd0);

    // stall_in holds EX; flush kills ID
    ins(1'b1, 6'h00, 6'h25, 5'd1, 5'd2, 5'd10);
    tick(); chk_ex("or", V | RW, 4'h1, 5'd10);
    ins(1'b1, 6'h0D, 6'h00, 5'd1, 5'd11, 5'd0);
    stall_in = 1'b1;
    tick(); chk_ex("stall_hold", V | RW, 4'h1, 5'd10);
    stall_in = 1'b0; flush = 1'b1;
    tick(); chk_ex("flush", 12'h000, 4'h0, 5'd0);
    flush = 1'b0;

    // SYSCALL: 3 drain cycles then one fire cycle
    ins(1'b1, 6'h00, 6'h0C, 5'd0, 5'd0, 5'd0);
    tick(); chk_sys("sc1", 1'b1, 1'b0, 1'b1); chk("sc1.valid", 32'(ex_valid), 32'd0);
    ins(1'b0, 6'h00, 6'h00, 5'd0, 5'd0, 5'd0);
    tick(); chk_sys("sc2", 1'b1, 1'b0, 1'b1); chk("sc2.valid", 32'(ex_valid), 32'd0);
    tick(); chk_sys("sc3", 1'b1, 1'b0, 1'b1); chk("sc3.valid", 32'(ex_valid), 32'd0);
    tick(); chk_sys("sc4", 1'b1, 1'b1, 1'b1); chk("sc4.valid", 32'(ex_valid), 32'd0);
    tick(); chk_sys("sc5", 1'b0, 1'b0, 1'b0);

    // SYSCALL with a 2-cycle stall_in mid-drain
    ins(1'b1, 6'h00, 6'h0C, 5'd0, 5'd0, 5'd0);
    tick(); chk_sys("scs1", 1'b1, 1'b0, 1'b1);
    ins(1'b0, 6'h00, 6'h00, 5'd0, 5'd0, 5'd0);
    tick(); chk_sys("scs2", 1'b1, 1'b0, 1'b1);
    stall_in = 1'b1;
    tick(); chk_sys("scs3", 1'b1, 1'b0, 1'b1);
    tick(); chk_sys("scs4", 1'b1, 1'b0, 1'b1);
    stall_in = 1'b0;
    tick(); chk_sys("scs5", 1'b1, 1'b0, 1'b1);
    tick(); chk_sys("scs6", 1'b1, 1'b1, 1'b1);
    tick(); chk_sys("scs7", 1'b0, 1'b0, 1'b0);

    // Flush with SYSCALL in ID: not accepted
    ins(1'b1, 6'h00, 6'h0C, 5'd0, 5'd0, 5'd0);
    flush = 1'b1;
    tick(); chk_sys("scf", 1'b0, 1'b0, 1'b0); chk("scf.valid", 32'(ex_valid), 32'd0);
    flush = 1'b0;

    // Flush during DRAIN aborts with no fire
    tick(); chk_sys("scd1", 1'b1, 1'b0, 1'b1);
    ins(1'b0, 6'h00, 6'h00, 5'd0, 5'd0, 5'd0);
    flush = 1'b1;
    tick(); chk_sys("scd2", 1'b0, 1'b0, 1'b0);
    flush = 1'b0;
    tick(); tick(); chk_sys("scd3", 1'b0, 1'b0, 1'b0);

    // Async reset during DRAIN
    ins(1'b1, 6'h00, 6'h0C, 5'd0, 5'd0, 5'd0);
    tick(); chk_sys("scr1", 1'b1, 1'b0, 1'b1);
    ins(1'b0, 6'h00, 6'h00, 5'd0, 5'd0, 5'd0);
    #1 rst = 1'b1;
    #1 chk_sys("scr_drain", 1'b0, 1'b0, 1'b0);
    #1 rst = 1'b0;

    // Async reset while firing
    ins(1'b1, 6'h00, 6'h0C, 5'd0, 5'd0, 5'd0);
    tick();
    ins(1'b0, 6'h00, 6'h00, 5'd0, 5'd0, 5'd0);
    tick(); tick(); tick(); chk_sys("scr_pre", 1'b1, 1'b1, 1'b1);
    #1 rst = 1'b1;
    #1 chk_sys("scr_fire", 1'b0, 1'b0, 1'b0);
    #1 rst = 1'b0;
    tick(); chk_sys("scr_after", 1'b0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipelined_control_unit.md
Name: pipelined_control_unit

Overview:
- Registered successor to the combinational MIPS control decoder.
- Decodes the ID-stage instruction and registers the control bundle into the ID/EX pipeline slot.
- Detects load-use hazards, applies flush and external stall, and sequences SYSCALL through a drain FSM.
- Sits between the IF/ID register and the EX stage of the pipelined CPU.

Parameters:
- ALUOP_W, 4: ALU op width. Base ops use low 3 bits with MSB 0. Must be >=4 when shift decode is compiled in.
- REG_ADDR_W, 5: register address width.
- DRAIN_CYCLES, 3: bubble cycles inserted before sys_fire (range 1..15).
- LINK_REG, 31: destination register for JAL.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- id_valid  in  1  ID slot holds a valid instruction.
- id_opcode  in  6  instr[31:26].
- id_func  in  6  instr[5:0].
- id_rs, id_rt, id_rd  in  REG_ADDR_W each  source/destination fields.
- stall_in  in  1  global freeze (memory wait).
- flush  in  1  branch/jump taken in EX; kill ID.
- id_stall  out  1  combinational; hold PC and IF/ID.
- ex_valid  out  1  EX slot valid.
- ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_alu_src, ex_branch, ex_bne, ex_jump, ex_jr, ex_jal  out  1 each  registered control.
- ex_alu_op  out  ALUOP_W  registered ALU op.
- ex_wreg  out  REG_ADDR_W  resolved destination (rd, rt or LINK_REG).
- ex_illegal  out  1  undefined opcode/func reached EX.
- sys_busy  out  1  FSM not IDLE.
- sys_fire  out  1  one-cycle syscall request to the environment.

Behaviour:
- Reset: all ex_* outputs, sys_busy and sys_fire are 0; FSM is IDLE; drain counter is 0.
- Latency: decode is registered, 1 cycle from ID to EX.
- Decode (opcode hex / func hex → alu_op):
  - R-type (op 00, alu_src=0, wreg=rd, reg_write=1): ADD 20 / ADDU 21 → 010; SUB 22 → 110; AND 24 → 000; OR 25 → 001; SLT 2A → 111.
  - ADDI 08, ADDIU 09 → 010, alu_src=1, wreg=rt.
  - ORI 0D → 001, alu_src=1, wreg=rt.
  - LUI 0F → 011, alu_src=1, wreg=rt.
  - LW 23: 010, mem_read=1, mem_to_reg=1, reg_write=1, wreg=rt.
  - SW 2B: 010, mem_write=1.
  - BEQ 04 / BNE 05: 110, branch=1; bne=1 for BNE only.
  - J 02: jump=1.
  - JAL 03: jump=1, jal=1, reg_write=1, wreg=LINK_REG.
  - JR (func 08): jr=1.
- No x values are driven; unused fields are 0.
- Undefined encoding: all controls 0, ex_illegal=1, ex_valid=1.
- uses_rt=1 for R-type, SW, BEQ and BNE.
- Load-use hazard: id_stall=1 when id_valid & ex_valid & ex_mem_read & ex_wreg!=0 & (ex_wreg==id_rs | (uses_rt & ex_wreg==id_rt)). The next EX slot is a bubble (ex_valid=0, all controls 0).
- Syscall FSM:
  - IDLE: valid SYSCALL (op 00, func 0C) not flushed or stalled → DRAIN; counter=DRAIN_CYCLES-1; SYSCALL itself enters EX as a bubble.
  - DRAIN: id_stall=1, bubbles issued, counter decrements; at 0 → FIRE.
  - FIRE: sys_fire=1 for exactly one cycle, id_stall=1 → IDLE.
- Priority on each edge: rst > stall_in > flush > hazard/syscall/normal.
  - stall_in=1: all EX registers, FSM state and counter hold; sys_fire holds its value only if already in FIRE.
  - flush=1 (no stall): next EX slot is a bubble. In DRAIN, flush aborts to IDLE with no fire; in FIRE it is ignored.
- id_valid=0 inserts a bubble.
- Reset asserted mid-drain clears the FSM immediately, and sys_fire drops asynchronously.

Optional Feature:
- Macro SHIFT_DECODE_EN.
- Defined: R-type SLL (func 00) → alu_op 1000 and SRL (func 02) → 1001, reg_write=1, wreg=rd, alu_src=0. The all-zero word (SLL $0,$0,0, i.e. NOP) has reg_write forced to 0.
- Undefined: func 00/02 decode as illegal, except the all-zero word, which decodes as a bubble-equivalent NOP (ex_valid=1, all controls 0, ex_illegal=0).

Test Plan:
- Reset then ADD $3,$1,$2 (op 00, func 20, rd=3) → next cycle ex_valid=1, alu_op=0010, reg_write=1, ex_wreg=3, all others 0.
- LW $5 followed by ADD $6,$5,$1 → id_stall=1 for one cycle, one EX bubble, then ADD issues; repeat with rd dependency on $0 → no stall.
- JAL → ex_jal=1, ex_jump=1, ex_reg_write=1, ex_wreg=31; BNE → branch=1, bne=1, alu_op=0110.
- SYSCALL with DRAIN_CYCLES=3 → sys_busy for 4 cycles, 3 bubbles, sys_fire high on 4th cycle only, then IDLE; stall_in pulse mid-drain extends by its length.
- flush asserted with SYSCALL in ID → FSM stays IDLE, bubble issued; async rst during DRAIN → sys_busy=0 immediately.
- Opcode 3F → ex_illegal=1, all controls 0; with SHIFT_DECODE_EN, func 02 → alu_op 1001, without it → ex_illegal=1.
